// File: rtl/rom.sv
// Read-only word store with a one-cycle registered read port.
// Contents are fixed at elaboration; there is no write or load path.
module rom #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic [ADDR_W-1:0] add,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  // Constant contents; addresses beyond DEPTH read back as zero.
  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    w = '0;
    if (32'(a) < 32'(DEPTH)) begin
      case (32'(a))
        32'd0:   w = DATA_W'(8'h12);
        32'd1:   w = DATA_W'(8'h34);
        32'd2:   w = DATA_W'(8'h56);
        32'd3:   w = DATA_W'(8'h78);
        32'd4:   w = DATA_W'(8'h9A);
        32'd5:   w = DATA_W'(8'hBC);
        32'd6:   w = DATA_W'(8'hDE);
        32'd7:   w = DATA_W'(8'hF0);
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  // Reset wins over a coincident read; an idle cycle keeps the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (rd) begin
      data_out   <= word_at(add);
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom.sv
// Directed and randomized bench for rom, checked against a word-table model
// that tracks the expected registered output.
module tb_rom;

  logic       clk;
  logic       rst;
  logic       rd;
  logic [2:0] add;
  logic [7:0] data_out;
  logic       data_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_words [8] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                  8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0] exp_data;
  logic       exp_valid;

  rom #(.ADDR_W(3), .DATA_W(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd         (rd),
    .add        (add),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " data"}, data_out, exp_data);
    check({tag, " valid"}, {7'd0, data_valid}, {7'd0, exp_valid});
  endtask

  // One clock cycle: drive mid-cycle, update the model at the edge, sample after it.
  task automatic apply_cycle(input string tag, input logic rst_v, input logic rd_v,
                             input logic [2:0] add_v);
    @(negedge clk);
    rst = rst_v;
    rd  = rd_v;
    add = add_v;
    if (rst_v) begin
      exp_data  = 8'h00;
      exp_valid = 1'b0;
    end
    @(posedge clk);
    if (!rst_v) begin
      if (rd_v) begin
        exp_data  = model_words[add_v];
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    #1;
    check_outputs(tag);
    // Address wiggles between edges must not reach data_out.
    add = 3'($urandom_range(0, 7));
  endtask

  initial begin
    rst = 1'b0;
    rd  = 1'b0;
    add = 3'd0;
    exp_data  = 8'h00;
    exp_valid = 1'b0;

    // Reset takes effect before any clock edge
    #1 rst = 1'b1;
    #3;
    check_outputs("reset_async_initial");

    // Reset held during a read request across two edges
    apply_cycle("reset_during_read_1", 1'b1, 1'b1, 3'd7);
    apply_cycle("reset_during_read_2", 1'b1, 1'b1, 3'd7);

    // First read after release
    apply_cycle("reset_release_read0", 1'b0, 1'b1, 3'd0);
    check("reset_release_const", data_out, 8'h12);

    // Descending sweep
    for (int a = 7; a >= 4; a--)
      apply_cycle($sformatf("desc_add%0d", a), 1'b0, 1'b1, 3'(a));

    // Full ascending sweep, back-to-back
    for (int a = 0; a < 8; a++)
      apply_cycle($sformatf("sweep_add%0d", a), 1'b0, 1'b1, 3'(a));

    // Hold with rd low while the address moves
    apply_cycle("hold_read3", 1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      apply_cycle($sformatf("hold_idle%0d", i), 1'b0, 1'b0, 3'd5);
      check($sformatf("hold_const%0d", i), data_out, 8'h78);
    end

    // Asynchronous reset mid-cycle after a read
    apply_cycle("async_read6", 1'b0, 1'b1, 3'd6);
    check("async_read6_const", data_out, 8'hDE);
    @(negedge clk);
    rst = 1'b1;
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    #2;
    check_outputs("async_reset_midcycle");
    apply_cycle("async_release_read0", 1'b0, 1'b1, 3'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 60; i++) begin
      logic r_rst;
      logic r_rd;
      r_rst = ($urandom_range(0, 9) == 0);
      r_rd  = ($urandom_range(0, 3) != 0);
      apply_cycle($sformatf("rand%0d", i), r_rst, r_rd, 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom.md
ROM -- requirements
Module: rom

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3, meaning address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning number of words, equal to 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port rd, input, 1 bit: read enable, sampled on the clk rising edge.
REQ-007 The block SHALL have port add, input, ADDR_W bits: read address, sampled with rd.
REQ-008 The block SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-009 The block SHALL have port data_valid, output, 1 bit: high for the cycle in which data_out holds a word read on the previous edge.

Function
REQ-010 The block SHALL hold fixed, non-writable contents: word0 0x12, word1 0x34, word2 0x56, word3 0x78, word4 0x9A, word5 0xBC, word6 0xDE, word7 0xF0.
REQ-011 The block SHALL define its contents at elaboration (constant table/case), with no write port and no runtime load path.
REQ-012 On a clk rising edge with rd=1 and rst=0, the block SHALL load data_out with word[add] and set data_valid=1.
REQ-013 Read latency SHALL be exactly one clock: data_out reflects the address sampled at the preceding rising edge.
REQ-014 On a clk rising edge with rd=0 and rst=0, data_out SHALL hold its previous value and data_valid SHALL go to 0.
REQ-015 Back-to-back reads with rd held at 1 SHALL give one new word per cycle, with no bubbles.
REQ-016 Address changes between clock edges SHALL NOT affect data_out; only the value sampled at the edge is used.
REQ-017 All address values 0..DEPTH-1 SHALL be valid, with no wrap-around or out-of-range handling needed at default widths.
REQ-018 If rd or add is X/Z at a sampling edge, the block SHALL NOT be required to produce defined data; verification drives only known values.

Reset
REQ-019 While rst=1, data_out SHALL be 0x00 and data_valid SHALL be 0, regardless of clk, rd and add.
REQ-020 Asserting rst SHALL take effect immediately, without waiting for a clock edge, including in the middle of a read sequence.
REQ-021 After rst deasserts, the first rising edge with rd=1 SHALL perform a normal read with one-cycle latency.
REQ-022 Reset and read SHALL NOT interact: if rst=1 at an edge with rd=1, the read is discarded.

Verification
REQ-023 Descending sweep: clk period 20 ns, rst=0, rd=1, add=7,6,5,4 changed every 20 ns, aligned mid-cycle. The bench SHALL see data_out = 0xF0, 0xDE, 0xBC, 0x9A on successive edges, with data_valid=1.
REQ-024 Full sweep: add=0..7 with rd=1. The bench SHALL see data_out = 0x12, 0x34, 0x56, 0x78, 0x9A, 0xBC, 0xDE, 0xF0, each one cycle after its address.
REQ-025 Hold: read add=3, giving 0x78; then set rd=0 and change add to 5 for 3 cycles. The bench SHALL see data_out stay 0x78 and data_valid=0.
REQ-026 Async reset: after reading 0xDE, assert rst between clock edges. The bench SHALL see data_out=0x00 and data_valid=0 before the next edge.
REQ-027 Reset release: deassert rst, then rd=1 with add=0. The bench SHALL see data_out=0x12 and data_valid=1 one edge later.
REQ-028 Reset during read: hold rst=1 with rd=1 and add=7 across 2 edges. The bench SHALL see data_out remain 0x00.
